// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the registered 1:N streaming demux.
// Select decoding is sized for the widest supported channel count.
package stream_demux_pkg;

    localparam int unsigned MAX_CH    = 16;
    localparam int unsigned MAX_SEL_W = 4;

    typedef logic [MAX_CH-1:0]    ch_mask_t;
    typedef logic [MAX_SEL_W-1:0] sel_t;

    function automatic logic sel_in_range(input sel_t sel, input int unsigned n);
        return 32'(sel) < n;
    endfunction

    // Out-of-range selects decode to an empty mask.
    function automatic ch_mask_t onehot(input sel_t sel, input int unsigned n);
        ch_mask_t m;
        m = '0;
        if (sel_in_range(sel, n)) begin
            m[sel] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/stream_demux.sv
// Registered 1:N_CH stream demux with unicast/broadcast delivery,
// a single holding stage and a sticky out-of-range select flag.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_bcast,
    output logic [N_CH-1:0]  out_valid,
    input  logic [N_CH-1:0]  out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err_sel,
    input  logic             err_clr
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic             err_q, err_d;
    logic [N_CH-1:0]  pend_rem;
    logic             accept;
    sel_t             sel_ext;

    assign sel_ext = sel_t'(in_sel);

    always_comb begin
        pend_rem = pend_q & ~out_ready;
        in_ready = (pend_rem == '0);
        accept   = in_valid & in_ready;
        pend_d   = pend_rem;
        data_d   = data_q;
        err_d    = err_q & ~err_clr;
        if (accept) begin
            if (in_bcast) begin
                pend_d = '1;
                data_d = in_data;
            end else if (sel_in_range(sel_ext, N_CH)) begin
                pend_d = N_CH'(onehot(sel_ext, N_CH));
                data_d = in_data;
            end else begin
                // Beat is consumed but dropped; holding stage is left as is.
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign out_valid = pend_q;
    assign out_data  = data_q;
    assign err_sel   = err_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-channel instance for the main
// features and a 3-channel instance for out-of-range selects.
module tb_stream_demux;

    logic       clk;
    logic       rst_n;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_bcast;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data;
    logic       err_sel;
    logic       err_clr;

    logic       in_valid3;
    logic       in_ready3;
    logic [7:0] in_data3;
    logic [1:0] in_sel3;
    logic       in_bcast3;
    logic [2:0] out_valid3;
    logic [2:0] out_ready3;
    logic [7:0] out_data3;
    logic       err_sel3;
    logic       err_clr3;

    int total;
    int bad;

    stream_demux #(.WIDTH(8), .N_CH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data),
        .err_sel(err_sel), .err_clr(err_clr)
    );

    stream_demux #(.WIDTH(8), .N_CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .in_sel(in_sel3), .in_bcast(in_bcast3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3),
        .err_sel(err_sel3), .err_clr(err_clr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string name, input logic [3:0] ev,
                            input logic [7:0] ed, input logic er);
        total++;
        if (out_valid !== ev || out_data !== ed || in_ready !== er) begin
            bad++;
            $display("FAIL %s: got valid=%b data=%h rdy=%b exp valid=%b data=%h rdy=%b",
                     name, out_valid, out_data, in_ready, ev, ed, er);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; in_data = 0; in_sel = 0; in_bcast = 0;
        out_ready = 0; err_clr = 0;
        in_valid3 = 0; in_data3 = 0; in_sel3 = 0; in_bcast3 = 0;
        out_ready3 = 0; err_clr3 = 0;
        step();
        step();
        chk_main("reset_hold", 4'b0000, 8'h00, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_main("reset_idle", 4'b0000, 8'h00, 1'b1);
        total++;
        if (err_sel !== 1'b0 || err_sel3 !== 1'b0 || out_valid3 !== 3'b000) begin
            bad++;
            $display("FAIL reset_err: got err=%b err3=%b v3=%b exp 0 0 000",
                     err_sel, err_sel3, out_valid3);
        end
    endtask

    task automatic test_unicast();
        out_ready = 4'b1111;
        in_valid = 1; in_bcast = 0;
        in_data = 8'hA5; in_sel = 2'd0;
        #1;
        chk_main("uni_pre", 4'b0000, 8'h00, 1'b1);
        step();
        chk_main("uni_a5", 4'b0001, 8'hA5, 1'b1);
        in_data = 8'h3C; in_sel = 2'd2;
        step();
        chk_main("uni_3c", 4'b0100, 8'h3C, 1'b1);
        in_data = 8'h7E; in_sel = 2'd3;
        step();
        chk_main("uni_7e", 4'b1000, 8'h7E, 1'b1);
        in_valid = 0;
        step();
        chk_main("uni_drain", 4'b0000, 8'h7E, 1'b1);
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1101;
        in_valid = 1; in_data = 8'h11; in_sel = 2'd1;
        step();
        in_data = 8'h22; in_sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_main("bp_hold", 4'b0010, 8'h11, 1'b0);
            step();
        end
        out_ready = 4'b1111;
        #1;
        chk_main("bp_release", 4'b0010, 8'h11, 1'b1);
        step();
        chk_main("bp_next", 4'b0001, 8'h22, 1'b1);
        in_valid = 0;
        step();
        chk_main("bp_drain", 4'b0000, 8'h22, 1'b1);
    endtask

    task automatic test_bcast();
        out_ready = 4'b0000;
        in_valid = 1; in_bcast = 1; in_data = 8'h5A; in_sel = 2'd1;
        step();
        in_valid = 0; in_bcast = 0;
        chk_main("bc_all", 4'b1111, 8'h5A, 1'b0);
        out_ready = 4'b0001;
        #1;
        chk_main("bc_r0001", 4'b1111, 8'h5A, 1'b0);
        step();
        chk_main("bc_1110", 4'b1110, 8'h5A, 1'b0);
        out_ready = 4'b0110;
        #1;
        chk_main("bc_r0110", 4'b1110, 8'h5A, 1'b0);
        step();
        chk_main("bc_1000", 4'b1000, 8'h5A, 1'b0);
        out_ready = 4'b1000;
        #1;
        chk_main("bc_r1000", 4'b1000, 8'h5A, 1'b1);
        step();
        chk_main("bc_done", 4'b0000, 8'h5A, 1'b1);
    endtask

    task automatic test_out_of_range();
        out_ready3 = 3'b111;
        in_valid3 = 1; in_bcast3 = 0; in_data3 = 8'h99; in_sel3 = 2'd3;
        #1;
        total++;
        if (in_ready3 !== 1'b1) begin
            bad++;
            $display("FAIL oor_ready: got %b exp 1", in_ready3);
        end
        step();
        in_valid3 = 0;
        total++;
        if (out_valid3 !== 3'b000 || err_sel3 !== 1'b1 || out_data3 !== 8'h00) begin
            bad++;
            $display("FAIL oor_drop: got v=%b err=%b d=%h exp v=000 err=1 d=00",
                     out_valid3, err_sel3, out_data3);
        end
        err_clr3 = 1;
        step();
        err_clr3 = 0;
        total++;
        if (err_sel3 !== 1'b0) begin
            bad++;
            $display("FAIL oor_clr: got %b exp 0", err_sel3);
        end
        err_clr3 = 1;
        in_valid3 = 1; in_data3 = 8'h77; in_sel3 = 2'd3;
        step();
        err_clr3 = 0; in_valid3 = 0;
        total++;
        if (err_sel3 !== 1'b1 || out_valid3 !== 3'b000) begin
            bad++;
            $display("FAIL oor_setwins: got err=%b v=%b exp err=1 v=000",
                     err_sel3, out_valid3);
        end
        in_valid3 = 1; in_data3 = 8'h42; in_sel3 = 2'd2;
        step();
        in_valid3 = 0;
        total++;
        if (out_valid3 !== 3'b100 || out_data3 !== 8'h42 || err_sel3 !== 1'b1) begin
            bad++;
            $display("FAIL oor_valid2: got v=%b d=%h err=%b exp v=100 d=42 err=1",
                     out_valid3, out_data3, err_sel3);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 4'b0000;
        in_valid = 1; in_bcast = 1; in_data = 8'hC3;
        step();
        in_valid = 0; in_bcast = 0;
        chk_main("ar_pend", 4'b1111, 8'hC3, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_main("ar_async", 4'b0000, 8'h00, 1'b1);
        #1;
        rst_n = 1'b1;
        step();
        out_ready = 4'b1111;
        in_valid = 1; in_data = 8'h4D; in_sel = 2'd2;
        step();
        in_valid = 0;
        chk_main("ar_fresh", 4'b0100, 8'h4D, 1'b1);
        step();
        chk_main("ar_drain", 4'b0000, 8'h4D, 1'b1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_unicast();
        test_backpressure();
        test_bcast();
        test_out_of_range();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
Parametrised 1:N_CH streaming demultiplexer. It is the registered, flow-controlled successor to the team's combinational 1:4 demux.
- One input beat (data + select) is captured into a single output holding stage.
- The beat is presented to one selected channel, or to all channels in broadcast mode, with per-channel valid/ready handshakes.
- It sits between a single producer and N_CH independent consumers in the datapath.

Parameters:
WIDTH, 8, data bits per beat
N_CH, 4, number of output channels (2..16; need not be a power of two)
SEL_W, $clog2(N_CH), select width (derived; not overridden)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  producer beat valid
in_ready  output  1  block can accept a beat this cycle
in_data  input  WIDTH  beat payload
in_sel  input  SEL_W  destination channel index
in_bcast  input  1  1 = deliver beat to all channels; in_sel ignored
out_valid  output  N_CH  per-channel valid
out_ready  input  N_CH  per-channel ready
out_data  output  WIDTH  payload, shared by all channels
err_sel  output  1  sticky: an out-of-range in_sel beat was dropped
err_clr  input  1  synchronous clear of err_sel

Behaviour:
- State: data_q[WIDTH] and pend_q[N_CH] (pending-delivery mask). "Busy" is defined as pend_q != 0.
- Reset (async, rst_n low): pend_q=0, data_q=0, err_sel=0. Consequently out_valid=0, out_data=0 and in_ready=1.
- Outputs:
  - out_valid = pend_q.
  - out_data = data_q.
  - in_ready = ((pend_q & ~out_ready) == 0), i.e. the holding stage empties this cycle or is already empty. This gives full throughput of 1 beat/cycle with no bubble.
- Output handshake: channel i completes when out_valid[i] & out_ready[i]. Its pend bit then clears. Other channels are unaffected.
- Accept: when in_valid & in_ready:
  - data_q <= in_data.
  - pend_q <= all-ones(N_CH) if in_bcast=1.
  - Otherwise pend_q <= onehot(in_sel) when in_sel < N_CH.
- Out-of-range select (in_sel >= N_CH, in_bcast=0):
  - The beat is still consumed (handshake completes) but dropped.
  - pend_q takes the cleared value (0 if no prior beat pending).
  - data_q is not loaded.
  - err_sel <= 1.
- Latency: accept at edge k, out_valid visible after edge k (cycle k+1). A consumer with ready held high completes in that cycle.
- Broadcast: the beat is retired only when every channel has handshaked. Channels may accept in different cycles, in any order. out_valid deasserts per channel as each completes.
- Simultaneous last-channel completion and new accept in the same cycle: the new beat is loaded and no cycle is lost.
- err_sel behaviour:
  - If err_clr and a new error occur in the same cycle, err_sel = 1 (set wins).
  - err_clr alone clears err_sel at the next edge.
- No combinational path from in_* to out_*. in_ready depends combinationally on out_ready only.
- Stability: while out_valid[i]=1 and out_ready[i]=0, out_valid[i] and out_data are held stable.
- in_valid may drop without acceptance. The block makes no assumption on producer stability.
- Reset mid-operation: pending beats are discarded immediately with no delivery, and all outputs return to their reset values asynchronously.

Decomposition:
- Package stream_demux_pkg holds:
  - function onehot(sel, n) returning an N_CH-bit mask.
  - the select-range check function.
- No sub-module is needed; the block is a single module with the holding stage and error flag.

Test Plan:
1. Reset/idle: rst_n=0 then 1 -> out_valid=4'b0000, out_data=8'h00, in_ready=1, err_sel=0.
2. Unicast streaming: beats A5(sel 0), 3C(sel 2), 7E(sel 3) on consecutive cycles with all out_ready=1 -> out_valid 0001, 0100, 1000 with data A5, 3C, 7E on successive cycles; in_ready stays 1.
3. Backpressure: beat 11 to sel 1 with out_ready[1]=0 for 3 cycles -> out_valid=0010, out_data=11 held; in_ready=0. Raise out_ready[1] -> in_ready=1 the same cycle; next beat 22 loads without a bubble.
4. Broadcast staggered: bcast beat 5A; out_ready 0001, then 0110, then 1000 -> out_valid 1111 → 1110 → 1000 → 0000; in_ready high only in the 1000-accept cycle.
5. Out-of-range (N_CH=3, SEL_W=2): beat 99 with sel=3 -> consumed, out_valid=000, err_sel=1. err_clr pulse -> err_sel=0. Repeat with err_clr asserted together with a new error -> err_sel stays 1.
6. Async reset mid-broadcast: pend=1111, assert rst_n=0 between edges -> out_valid=0000 immediately, data reset; after release, a fresh beat to sel 2 delivers normally.
